// File: rtl/image_mem_arbiter.sv
// image_mem_arbiter: shares the dual-bank image memory between CPU and video scan-out
//
// Ports:
//   clk, rst_n                           clock, asynchronous active-low reset
//   cpu_req/we/addr/wdata -> cpu_gnt     CPU access request, held until granted
//   cpu_rvalid, cpu_rdata                CPU read return (pulse; data holds)
//   vid_req/addr -> vid_gnt              video read request, held until granted
//   vid_rvalid, vid_rdata                video read return (pulse; data holds)
//   mem_en/we/re/addr/wdata, mem_rdata   memory port (one access per cycle)
module image_mem_arbiter #(
    parameter int ADDR_W     = 15,
    parameter int DATA_W     = 16,
    parameter int READ_LAT   = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              vid_req,
    input  logic [ADDR_W-1:0] vid_addr,
    output logic              vid_gnt,
    output logic              vid_rvalid,
    output logic [DATA_W-1:0] vid_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic              mem_re,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);
    typedef enum logic {VID_PRI, CPU_PRI} state_t;
    localparam int CW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    state_t            state;
    logic [CW-1:0]     starve_cnt, cnt_next;
    logic [READ_LAT-1:0] pipe_valid, pipe_cpu;
    logic [DATA_W-1:0] cpu_hold, vid_hold;
    // grants are forced low while reset is asserted
    always_comb begin
        cpu_gnt   = rst_n && cpu_req && (state == CPU_PRI || !vid_req);
        vid_gnt   = rst_n && vid_req && !cpu_gnt;
        mem_en    = cpu_gnt || vid_gnt;
        mem_we    = cpu_gnt && cpu_we;
        mem_re    = vid_gnt || (cpu_gnt && !cpu_we);
        mem_addr  = cpu_gnt ? cpu_addr : vid_gnt ? vid_addr : '0;
        mem_wdata = cpu_gnt ? cpu_wdata : '0;
        // counter never needs to pass STARVE_MAX: reaching it forces a CPU grant
        cnt_next  = cpu_gnt ? '0 : (cpu_req && starve_cnt != CW'(STARVE_MAX)) ? starve_cnt + 1'b1 : starve_cnt;
    end
    // tail of the return pipeline lines up with mem_rdata for that read
    assign cpu_rvalid = pipe_valid[READ_LAT-1] && pipe_cpu[READ_LAT-1];
    assign vid_rvalid = pipe_valid[READ_LAT-1] && !pipe_cpu[READ_LAT-1];
    assign cpu_rdata  = cpu_rvalid ? mem_rdata : cpu_hold;
    assign vid_rdata  = vid_rvalid ? mem_rdata : vid_hold;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= VID_PRI;
            starve_cnt <= '0;
            pipe_valid <= '0;
            pipe_cpu   <= '0;
            cpu_hold   <= '0;
            vid_hold   <= '0;
        end else begin
            starve_cnt <= cnt_next;
            // checking the threshold first keeps STARVE_MAX=0 in CPU_PRI for good
            state      <= (cnt_next == CW'(STARVE_MAX)) ? CPU_PRI : cpu_gnt ? VID_PRI : state;
            pipe_valid <= (pipe_valid << 1) | READ_LAT'(mem_re);
            pipe_cpu   <= (pipe_cpu << 1) | READ_LAT'(cpu_gnt);
            if (cpu_rvalid) cpu_hold <= mem_rdata;
            if (vid_rvalid) vid_hold <= mem_rdata;
        end
    end
endmodule

// File: tb/tb_image_mem_arbiter.sv
// tb_image_mem_arbiter: randomized self-checking bench against a transaction-level model
module tb_image_mem_arbiter;
    localparam int AW = 15, DW = 16, RL = 1, SM = 4;
    logic clk = 0, rst_n = 0;
    logic cpu_req, cpu_we, cpu_gnt, cpu_rvalid, vid_req, vid_gnt, vid_rvalid;
    logic mem_en, mem_we, mem_re;
    logic [AW-1:0] cpu_addr, vid_addr, mem_addr;
    logic [DW-1:0] cpu_wdata, cpu_rdata, vid_rdata, mem_wdata, mem_rdata;
    always #5 clk = ~clk;
    image_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .READ_LAT(RL), .STARVE_MAX(SM)) dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .vid_req(vid_req), .vid_addr(vid_addr), .vid_gnt(vid_gnt),
        .vid_rvalid(vid_rvalid), .vid_rdata(vid_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_re(mem_re), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );
    function automatic logic [DW-1:0] pat(int a);
        return DW'(a * 40503 + 16'h1234);
    endfunction
    // synchronous memory with RL-cycle read latency
    logic [DW-1:0] mem [0:32767];
    logic [DW-1:0] rd_pipe [RL];
    assign mem_rdata = rd_pipe[RL-1];
    initial begin
        for (int i = 0; i < 32768; i++) mem[i] = pat(i);
        forever begin
            @(posedge clk);
            if (mem_re) rd_pipe[0] <= mem[mem_addr];
            for (int k = 1; k < RL; k++) rd_pipe[k] <= rd_pipe[k-1];
            if (mem_en && mem_we) mem[mem_addr] = mem_wdata;
        end
    end
    // reference model: shadow memory, expected returns, CPU denial streak
    typedef struct {int due; bit cpu; logic [DW-1:0] d;} ret_t;
    ret_t q[$];
    logic [DW-1:0] ref_mem [0:32767];
    logic [DW-1:0] last_c, last_v;
    int checks = 0, errors = 0, cyc = 0, streak = 0;
    bit gc, gv;
    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask
    task automatic run_cycle(output bit oc, output bit ov);
        bit cw, vw, ec, ev;
        logic [DW-1:0] ed;
        #1;
        cw = cpu_req && (!vid_req || streak >= SM);
        vw = vid_req && !cw;
        oc = cpu_gnt;
        ov = vid_gnt;
        check("cpu_gnt", 32'(cpu_gnt), 32'(cw));
        check("vid_gnt", 32'(vid_gnt), 32'(vw));
        check("mem_en", 32'(mem_en), 32'(cw || vw));
        check("mem_we", 32'(mem_we), 32'(cw && cpu_we));
        check("mem_re", 32'(mem_re), 32'(vw || (cw && !cpu_we)));
        check("mem_addr", 32'(mem_addr), 32'(cw ? cpu_addr : vw ? vid_addr : '0));
        check("mem_wdata", 32'(mem_wdata), 32'(cw ? cpu_wdata : '0));
        ec = 0; ev = 0; ed = '0;
        if (q.size() > 0 && q[0].due == cyc) begin
            ec = q[0].cpu; ev = !q[0].cpu; ed = q[0].d;
            void'(q.pop_front());
        end
        check("cpu_rvalid", 32'(cpu_rvalid), 32'(ec));
        check("vid_rvalid", 32'(vid_rvalid), 32'(ev));
        if (ec) last_c = ed;
        if (ev) last_v = ed;
        check("cpu_rdata", 32'(cpu_rdata), 32'(last_c));
        check("vid_rdata", 32'(vid_rdata), 32'(last_v));
        streak = cw ? 0 : cpu_req ? streak + 1 : streak;
        if (cw && cpu_we) ref_mem[cpu_addr] = cpu_wdata;
        if (cw && !cpu_we) q.push_back('{cyc + RL, 1'b1, ref_mem[cpu_addr]});
        if (vw) q.push_back('{cyc + RL, 1'b0, ref_mem[vid_addr]});
        @(posedge clk);
        cyc++;
        #1;
    endtask
    task automatic check_idle(string tag);
        check({tag, "_cpu_gnt"}, 32'(cpu_gnt), 0);
        check({tag, "_vid_gnt"}, 32'(vid_gnt), 0);
        check({tag, "_mem_en"}, 32'(mem_en), 0);
        check({tag, "_mem_we"}, 32'(mem_we), 0);
        check({tag, "_mem_re"}, 32'(mem_re), 0);
        check({tag, "_cpu_rvalid"}, 32'(cpu_rvalid), 0);
        check({tag, "_vid_rvalid"}, 32'(vid_rvalid), 0);
    endtask
    task automatic contention(int n);
        for (int i = 0; i < n; i++) begin
            run_cycle(gc, gv);
            check("pattern", 32'(gc), 32'(i % 5 == 4));
            if (gc) cpu_addr = AW'($urandom);
            else vid_addr = AW'($urandom);
        end
    endtask
    initial begin
        for (int i = 0; i < 32768; i++) ref_mem[i] = pat(i);
        last_c = '0; last_v = '0;
        cpu_req = 1; vid_req = 1; cpu_we = 0; cpu_addr = 15'h0123; vid_addr = 15'h4321; cpu_wdata = '0;
        #2;
        check_idle("rst");
        check("rst_cpu_rdata", 32'(cpu_rdata), 0);
        check("rst_vid_rdata", 32'(vid_rdata), 0);
        @(posedge clk);
        #1;
        check_idle("rst2");
        cpu_req = 0; vid_req = 0;
        rst_n = 1;
        // solo CPU write then read of the same location
        cpu_req = 1; cpu_we = 1; cpu_addr = 15'h4005; cpu_wdata = 16'hBEEF;
        run_cycle(gc, gv);
        check("solo_wr_gnt", 32'(gc), 1);
        cpu_we = 0;
        run_cycle(gc, gv);
        check("solo_rd_gnt", 32'(gc), 1);
        cpu_req = 0;
        repeat (RL) run_cycle(gc, gv);
        check("solo_rdata", 32'(cpu_rdata), 32'h0000BEEF);
        // both requesting continuously: 4 video grants then one CPU grant
        cpu_req = 1; cpu_we = 0; vid_req = 1;
        contention(15);
        cpu_req = 0; vid_req = 0;
        repeat (RL) run_cycle(gc, gv);
        // alternating pipelined reads across both banks
        for (int i = 0; i < 20; i++) begin
            cpu_req = i[0]; vid_req = !i[0]; cpu_we = 0;
            cpu_addr = {i[1], 14'($urandom)};
            vid_addr = {!i[1], 14'($urandom)};
            run_cycle(gc, gv);
        end
        cpu_req = 0; vid_req = 0; gc = 1; gv = 1;
        // random traffic over a small address window to exercise read-after-write
        for (int i = 0; i < 400; i++) begin
            if (!cpu_req || gc) begin
                cpu_req = ($urandom % 3) != 0;
                cpu_we = $urandom % 2;
                cpu_addr = {1'($urandom), 10'd0, 4'($urandom)};
                cpu_wdata = DW'($urandom);
            end
            if (!vid_req || gv) begin
                vid_req = ($urandom % 4) != 0;
                vid_addr = {1'($urandom), 10'd0, 4'($urandom)};
            end
            run_cycle(gc, gv);
        end
        cpu_req = 0; vid_req = 0;
        repeat (RL + 1) run_cycle(gc, gv);
        // reset while a video read is in flight and the CPU has been denied twice
        cpu_req = 1; cpu_we = 0; vid_req = 1;
        run_cycle(gc, gv);
        run_cycle(gc, gv);
        #1;
        check("flight_vid_gnt", 32'(vid_gnt), 1);
        rst_n = 0;
        q.delete(); streak = 0; last_c = '0; last_v = '0;
        #1;
        check_idle("flight_rst");
        @(posedge clk);
        cyc++;
        #1;
        check_idle("flight_rst2");
        check("flight_cpu_rdata", 32'(cpu_rdata), 0);
        check("flight_vid_rdata", 32'(vid_rdata), 0);
        rst_n = 1;
        contention(10);
        cpu_req = 0; vid_req = 0;
        repeat (RL + 1) run_cycle(gc, gv);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
